pipe_hazard_ctrl: RTL

- Centralised hazard and forwarding controller for the 5-stage core.
- Replaces the separate hazard-detection and forward units with one parametrised scoreboard.
- Tracks in-flight register writers from EX through write-back over DEPTH entries and supports a configurable load latency (LOAD_LAT).
- Generates the stall, bubble, flush and per-operand forwarding selects consumed by the pipeline top.

---
 rtl/pipe_hazard_pkg.sv | 31 +++
 rtl/pipe_scoreboard.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_pkg.sv
// Shared types, constants and the youngest-ready forwarding picker for the
// pipeline hazard/forwarding controller.
package pipe_hazard_pkg;

    localparam int DEST_W    = 8;   // widest register index the scoreboard can hold
    localparam int MAX_DEPTH = 8;
    localparam int SEL_W     = 3;

    localparam logic [SEL_W-1:0]  FWD_NONE = '0;
    localparam logic [DEST_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              ld;
        logic [DEST_W-1:0] dest;
    } sb_entry_t;

    // Lowest set index in 1..MAX_DEPTH-1 wins: that entry holds the youngest writer.
    function automatic logic [SEL_W-1:0] fwd_pick(input logic [MAX_DEPTH-1:0] hit);
        logic [SEL_W-1:0] sel;
        sel = FWD_NONE;
        for (int k = MAX_DEPTH - 1; k >= 1; k--) begin
            if (hit[k]) begin
                sel = SEL_W'(k);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight writer tracker: entry 0 is EX, entry DEPTH-1 is write-back.
// Entries shift one stage per cycle; downstream stages never stall.
module pipe_scoreboard
    import pipe_hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  sb_entry_t        push_entry,
    output sb_entry_t        entry [DEPTH],
    output logic [DEPTH-1:0] ready
);

    sb_entry_t entry_reg [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_reg[k] <= '0;
            end
        end else begin
            entry_reg[0] <= push_entry;
            for (int k = 1; k < DEPTH; k++) begin
                entry_reg[k] <= entry_reg[k-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ready
            assign entry[gi] = entry_reg[gi];
            // Load data only exists from stage LOAD_LAT onward.
            assign ready[gi] = entry_reg[gi].valid && entry_reg[gi].wr &&
                               (!entry_reg[gi].ld || (gi >= LOAD_LAT));
        end
    endgenerate

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Unified stall / flush / forwarding controller for the 5-stage core.
// Define PIPE_PERF_CNT_EN to add saturating stall and flush event counters.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int FW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              id_is_branch,
    input  logic              id_branch_taken,
    output logic              stall,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              if_flush,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    sb_entry_t         entry [DEPTH];
    sb_entry_t         push_entry;
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  lu_hit, br_hit, fa_hit, fb_hit, late_hit;
    logic [REG_AW-1:0] ex_rs_reg, ex_rt_reg;
    logic              ex_use_rs_reg, ex_use_rt_reg;
    logic              flush_kill_reg;

    pipe_scoreboard #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .push_entry (push_entry),
        .entry      (entry),
        .ready      (ready)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic live, rs_m, rt_m, exa_m, exb_m;
            assign live  = entry[gi].valid && entry[gi].wr;
            assign rs_m  = id_use_rs && (entry[gi].dest == DEST_W'(id_rs));
            assign rt_m  = id_use_rt && (entry[gi].dest == DEST_W'(id_rt));
            assign exa_m = ex_use_rs_reg && (entry[gi].dest == DEST_W'(ex_rs_reg));
            assign exb_m = ex_use_rt_reg && (entry[gi].dest == DEST_W'(ex_rt_reg));
            assign lu_hit[gi]   = (gi + 1 < LOAD_LAT) && live && entry[gi].ld && (rs_m || rt_m);
            // Write-back entry excluded: the register file writes before it is read.
            assign br_hit[gi]   = (gi <= DEPTH - 2) && live && (rs_m || rt_m);
            assign fa_hit[gi]   = (gi != 0) && ready[gi] && exa_m;
            assign fb_hit[gi]   = (gi != 0) && ready[gi] && exb_m;
            assign late_hit[gi] = (gi != 0) && live && !ready[gi] && (exa_m || exb_m);
        end
    endgenerate

    assign stall       = rst && id_valid && ((|lu_hit) || (id_is_branch && (|br_hit)));
    assign if_flush    = rst && id_valid && id_is_branch && id_branch_taken && !stall;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = stall;
    assign fwd_a       = FW'(fwd_pick(MAX_DEPTH'(fa_hit)));
    assign fwd_b       = FW'(fwd_pick(MAX_DEPTH'(fb_hit)));

    always_comb begin
        push_entry = '0;
        if (id_valid && !stall && !flush_kill_reg) begin
            push_entry.valid = 1'b1;
            push_entry.wr    = id_regwrite && (DEST_W'(id_dest) != REG_ZERO);
            push_entry.ld    = id_is_load;
            push_entry.dest  = DEST_W'(id_dest);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_rs_reg      <= '0;
            ex_rt_reg      <= '0;
            ex_use_rs_reg  <= 1'b0;
            ex_use_rt_reg  <= 1'b0;
            flush_kill_reg <= 1'b0;
        end else begin
            if (id_valid && !stall) begin
                ex_rs_reg     <= id_rs;
                ex_rt_reg     <= id_rt;
                ex_use_rs_reg <= id_use_rs;
                ex_use_rt_reg <= id_use_rt;
            end else begin
                ex_rs_reg     <= '0;
                ex_rt_reg     <= '0;
                ex_use_rs_reg <= 1'b0;
                ex_use_rt_reg <= 1'b0;
            end
            // The squashed slot stays marked until it actually leaves ID.
            flush_kill_reg <= if_flush || (flush_kill_reg && stall);
        end
    end

    a_no_late_operand: assert property (@(posedge clk) disable iff (!rst) late_hit == '0);

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_cnt_reg, perf_flush_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt_reg <= '0;
            perf_flush_cnt_reg <= '0;
        end else begin
            if (stall && (perf_stall_cnt_reg != 32'hFFFF_FFFF)) begin
                perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
            end
            if (if_flush && (perf_flush_cnt_reg != 32'hFFFF_FFFF)) begin
                perf_flush_cnt_reg <= perf_flush_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_reg;
    assign perf_flush_cnt = perf_flush_cnt_reg;
`endif

endmodule
